mux_sel_sequencer: RTL and testbench
====================================

// Module: mux_sel_sequencer
// PURPOSE
//   Upstream control stage for the 8:1 decoder/tristate mux. Round-robin
//   arbitrates eight channel requests and drives the mux select s[2:0].
//   Holds each selection for a bounded dwell window. Inserts a break-before-make
//   gap (all grants low) between selections so the tristate bus never has two
//   enabled drivers.
// PARAMETERS
//   N_CH      8   channel count; fixed at 8 to match the 3-bit mux select
//   MIN_DWELL 4   minimum cycles sel_valid stays high before ack is honoured (>=1)
//   MAX_DWELL 64  timeout in cycles of sel_valid high; 0 disables timeout (<=255)
// PORTS
//   clk        in   1  rising-edge clock
//   rst        in   1  asynchronous, active-high reset
//   req        in   8  per-channel request, level-sensitive
//   ack        in   1  consumer has sampled mux output y for the current channel
//   s          out  3  mux select, index of granted channel
//   grant      out  8  one-hot grant, 0 when no channel is granted
//   sel_valid  out  1  s is settled and y is valid to sample
//   timeout    out  1  one-cycle pulse on timeout release
//   busy       out  1  high in SETTLE and DWELL
// BEHAVIOUR
//   Reset (async): s=0, grant=0, sel_valid=0, timeout=0, busy=0, state=IDLE,
//     last=7 (ch0 has highest priority first), dwell count cnt=0.
//   States: IDLE -> SETTLE -> DWELL -> IDLE. All outputs are registered.
//   IDLE: when |req, pick the first requesting channel searching last+1 .. last
//     with wrap-around. Next edge: s<=idx, grant<=1<<idx, state<=SETTLE.
//     With no request, stay in IDLE. s keeps its last value; grant=0.
//   SETTLE: one cycle for decoder/tristate settling. sel_valid=0.
//     Next edge: sel_valid<=1, cnt<=0, state<=DWELL.
//   DWELL: cnt increments every cycle, saturating at 255.
//     Release when any of these holds:
//       (a) ack && cnt>=MIN_DWELL-1  (normal)
//       (b) !req[s]                  (abort, no timeout pulse)
//       (c) MAX_DWELL!=0 && cnt==MAX_DWELL-1 && !(a) && !(b)
//           -> timeout=1 for exactly one cycle
//     ack with cnt<MIN_DWELL-1 is ignored and not remembered.
//     If (a) and (b) are both true in the same cycle, treat as a normal release.
//     On release edge: grant<=0, sel_valid<=0, last<=s, state<=IDLE.
//   Latency: req rises in IDLE at cycle 0 -> grant/s valid after edge 1,
//     sel_valid high after edge 2. Minimum spacing between grants is one
//     IDLE cycle with grant=0.
//   Invariants: grant is one-hot or zero; grant!=0 implies grant==1<<s;
//     sel_valid implies grant!=0.
//   New requests arriving during SETTLE/DWELL do not preempt the current grant.
//   Reset asserted mid-operation clears all outputs immediately without
//     waiting for clk. On reset release, arbitration restarts from ch0.
// STRUCTURE
//   Package mux_sel_pkg: N_CH=8, SEL_W=3, CNT_W=8, state enum {IDLE,SETTLE,DWELL}.
//   Sub-module rr_pick (combinational): inputs req[7:0], last[2:0];
//     outputs found, idx[2:0]. Rotate-priority search.
//   Top module holds the FSM, dwell counter, last pointer and output registers.
// TESTING
//   1 req=8'h08 held, ack at cnt=5 -> s=3, grant=8'h08 at edge 1,
//     sel_valid at edge 2, release after ack, grant=0 for one cycle.
//   2 req=8'hFF, ack always high -> grants cycle ch0..ch7 then ch0.
//     Each sel_valid lasts exactly MIN_DWELL=4 cycles.
//   3 req=8'h01, ack pulses only at cnt=1 -> ignored, sel_valid stays high.
//     Hold ack high from cnt=3 -> release at cnt=3.
//   4 req=8'h21, ack never -> timeout pulses once at cnt=63 (ch0).
//     Next grant is ch5.
//   5 req[2] drops at cnt=2 of DWELL -> release next edge, timeout stays 0.
//   6 rst asserted mid-DWELL on ch6 -> grant/sel_valid/s go to 0 before
//     the next clk. After release with req=8'h41, ch0 is granted first.
//   All tests: assert the invariants every cycle.

Source files
------------

// File: rtl/mux_sel_sequencer_pkg.sv
// Shared types and sizes for the mux select sequencer.
//   N_CH  : channel count, tied to the 3-bit mux select
//   SEL_W : select width
//   CNT_W : dwell counter width (saturates at 255)
package mux_sel_pkg;
    localparam int N_CH  = 8;
    localparam int SEL_W = 3;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DWELL  = 2'd2
    } state_e;
endpackage

// File: rtl/mux_sel_sequencer_if.sv
// Request/select bundle between the channel requesters/consumer and the
// sequencer.
//   master : sequencer side (drives s, grant, sel_valid, timeout, busy)
//   slave  : requester/consumer side (drives req, ack)
interface mux_sel_if;
    import mux_sel_pkg::*;

    logic [N_CH-1:0]  req;
    logic             ack;
    logic [SEL_W-1:0] s;
    logic [N_CH-1:0]  grant;
    logic             sel_valid;
    logic             timeout;
    logic             busy;

    modport master (input req, ack, output s, grant, sel_valid, timeout, busy);
    modport slave  (output req, ack, input s, grant, sel_valid, timeout, busy);
endinterface

// File: rtl/mux_sel_sequencer_rr_pick.sv
// Combinational round-robin picker.
//   req   in  : per-channel request
//   last  in  : most recently served channel (lowest priority)
//   found out : any request present
//   idx   out : first requester searching last+1 .. last with wrap-around
module rr_pick
    import mux_sel_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] last,
    output logic             found,
    output logic [SEL_W-1:0] idx
);
    always_comb begin
        logic [SEL_W-1:0] ch;
        found = 1'b0;
        idx   = last;
        ch    = '0;
        // Offset N_CH wraps to last itself, so it is checked last.
        for (int i = 1; i <= N_CH; i++) begin
            ch = last + SEL_W'(i);
            if (!found && req[ch]) begin
                found = 1'b1;
                idx   = ch;
            end
        end
    end
endmodule

// File: rtl/mux_sel_sequencer.sv
// Round-robin select sequencer for the 8:1 decoder/tristate mux.
// Grants one channel at a time, holds it for a bounded dwell window and
// leaves at least one all-zero grant cycle between selections.
//   clk, rst  : clock, async active-high reset
//   bus       : mux_sel_if.master (req/ack in; s/grant/sel_valid/timeout/busy out)
//   MIN_DWELL : cycles of sel_valid before ack is honoured (>=1)
//   MAX_DWELL : sel_valid timeout in cycles, 0 disables (<=255)
module mux_sel_sequencer
    import mux_sel_pkg::*;
#(
    parameter int MIN_DWELL = 4,
    parameter int MAX_DWELL = 64
)(
    input  logic     clk,
    input  logic     rst,
    mux_sel_if.master bus
);
    localparam logic [CNT_W-1:0] MIN_M1 = CNT_W'(MIN_DWELL - 1);
    localparam logic [CNT_W-1:0] MAX_M1 = CNT_W'((MAX_DWELL == 0) ? 0 : MAX_DWELL - 1);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] s_q, s_d, last_q, last_d;
    logic [N_CH-1:0]  grant_q, grant_d;
    logic             sel_valid_q, sel_valid_d;
    logic             timeout_q, timeout_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             found;
    logic [SEL_W-1:0] pick_idx;
    logic             rel_norm, rel_abort, rel_to;

    rr_pick u_pick (
        .req   (bus.req),
        .last  (last_q),
        .found (found),
        .idx   (pick_idx)
    );

    // Release causes; a normal release wins over an abort, and timeout only
    // fires when neither of the others applies.
    assign rel_norm  = bus.ack && (cnt_q >= MIN_M1);
    assign rel_abort = !bus.req[s_q];
    assign rel_to    = (MAX_DWELL != 0) && (cnt_q == MAX_M1) && !rel_norm && !rel_abort;

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        last_d      = last_q;
        grant_d     = grant_q;
        sel_valid_d = sel_valid_q;
        busy_d      = busy_q;
        cnt_d       = cnt_q;
        timeout_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    s_d     = pick_idx;
                    grant_d = {{(N_CH-1){1'b0}}, 1'b1} << pick_idx;
                    busy_d  = 1'b1;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                sel_valid_d = 1'b1;
                cnt_d       = '0;
                state_d     = DWELL;
            end
            DWELL: begin
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                if (rel_norm || rel_abort || rel_to) begin
                    grant_d     = '0;
                    sel_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    last_d      = s_q;
                    timeout_d   = rel_to;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            s_q         <= '0;
            last_q      <= SEL_W'(N_CH - 1);
            grant_q     <= '0;
            sel_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            sel_valid_q <= sel_valid_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.s         = s_q;
    assign bus.grant     = grant_q;
    assign bus.sel_valid = sel_valid_q;
    assign bus.timeout   = timeout_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mux_sel_sequencer.sv
module tb_mux_sel_sequencer;
    localparam int MIN_DWELL = 4;
    localparam int MAX_DWELL = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_sel_if bus ();

    mux_sel_sequencer #(.MIN_DWELL(MIN_DWELL), .MAX_DWELL(MAX_DWELL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int errors = 0;
    int checks = 0;

    // Transaction-level reference: current channel (-1 = none) and age in
    // cycles since the grant edge (age 0 = settling, dwell count = age-1).
    int m_cur, m_age, m_last, m_s;
    bit m_to;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cur = -1; m_age = 0; m_last = 7; m_s = 0; m_to = 0;
    endtask

    task automatic model_step();
        int c;
        bit a, b, t;
        m_to = 0;
        if (m_cur < 0) begin
            for (int k = 1; k <= 8; k++) begin
                int ch = (m_last + k) % 8;
                if (m_cur < 0 && bus.req[ch]) begin
                    m_cur = ch; m_s = ch; m_age = 0;
                end
            end
        end else if (m_age == 0) begin
            m_age = 1;
        end else begin
            c = (m_age - 1 > 255) ? 255 : m_age - 1;
            a = bus.ack && (c >= MIN_DWELL - 1);
            b = !bus.req[m_cur];
            t = (MAX_DWELL != 0) && (c == MAX_DWELL - 1) && !a && !b;
            if (a || b || t) begin
                m_last = m_cur; m_cur = -1; m_to = t;
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic check_all();
        chk("grant", bus.grant, (m_cur >= 0) ? (32'd1 << m_cur) : 32'd0);
        chk("s", bus.s, m_s);
        chk("sel_valid", bus.sel_valid, (m_cur >= 0 && m_age >= 1) ? 1 : 0);
        chk("timeout", bus.timeout, m_to);
        chk("busy", bus.busy, (m_cur >= 0) ? 1 : 0);
        chk("inv_onehot", $onehot0(bus.grant), 1);
        if (bus.grant != 0) chk("inv_grant_s", bus.grant, 32'd1 << bus.s);
        if (bus.sel_valid)  chk("inv_sv_grant", (bus.grant != 0), 1);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Advance until the DUT is dwelling with count == c.
    task automatic wait_cnt(input int c);
        int n = 0;
        while (!(m_cur >= 0 && m_age >= 1 && m_age - 1 == c) && n < 300) begin
            cyc();
            n++;
        end
        if (n >= 300) chk("wait_cnt_bound", 0, 1);
    endtask

    initial begin
        int k, len, svlen, n;
        logic [7:0] prev;

        bus.req = '0;
        bus.ack = 1'b0;
        rst = 1'b1;
        model_reset();
        #12;
        chk("rst_s", bus.s, 0);
        chk("rst_grant", bus.grant, 0);
        chk("rst_sel_valid", bus.sel_valid, 0);
        chk("rst_timeout", bus.timeout, 0);
        chk("rst_busy", bus.busy, 0);
        @(negedge clk);
        rst = 1'b0;

        // 1: single channel, ack at cnt=5
        bus.req = 8'h08;
        cyc();
        chk("t1_grant", bus.grant, 8'h08);
        chk("t1_s", bus.s, 3);
        chk("t1_sv_lo", bus.sel_valid, 0);
        cyc();
        chk("t1_sv_hi", bus.sel_valid, 1);
        wait_cnt(5);
        bus.ack = 1'b1;
        cyc();
        bus.ack = 1'b0;
        chk("t1_rel_grant", bus.grant, 0);
        bus.req = 8'h00;
        cyc();
        chk("t1_gap", bus.grant, 0);

        // 2: all requesting, ack always high
        do_reset();
        bus.req = 8'hFF;
        bus.ack = 1'b1;
        k = 0; len = 0; prev = '0; n = 0;
        while (k < 9 && n < 100) begin
            cyc();
            n++;
            if (prev == 0 && bus.grant != 0) begin
                chk("t2_order", bus.s, k % 8);
                k++;
            end
            if (bus.sel_valid) len++;
            else if (len > 0) begin
                chk("t2_dwell", len, MIN_DWELL);
                len = 0;
            end
            prev = bus.grant;
        end
        chk("t2_count", k, 9);
        bus.ack = 1'b0;

        // 3: early ack ignored, later ack honoured at cnt=3
        do_reset();
        bus.req = 8'h01;
        wait_cnt(1);
        bus.ack = 1'b1;
        cyc();
        bus.ack = 1'b0;
        chk("t3_early_ack", bus.sel_valid, 1);
        wait_cnt(3);
        bus.ack = 1'b1;
        cyc();
        chk("t3_release", bus.sel_valid, 0);
        bus.ack = 1'b0;
        bus.req = 8'h00;
        cyc();

        // 4: timeout on ch0, then ch5
        do_reset();
        bus.req = 8'h21;
        svlen = 0; n = 0;
        while (n < 200) begin
            cyc();
            n++;
            if (bus.sel_valid) svlen++;
            if (bus.timeout) break;
        end
        chk("t4_timeout_seen", bus.timeout, 1);
        chk("t4_sv_len", svlen, MAX_DWELL);
        chk("t4_s", bus.s, 0);
        cyc();
        chk("t4_pulse_len", bus.timeout, 0);
        chk("t4_next", bus.grant, 8'h20);
        bus.req = 8'h00;
        wait_cnt(0);
        cyc();

        // 5: request drop aborts without timeout
        do_reset();
        bus.req = 8'h04;
        wait_cnt(2);
        bus.req = 8'h00;
        cyc();
        chk("t5_grant", bus.grant, 0);
        chk("t5_timeout", bus.timeout, 0);
        cyc();

        // 6: async reset mid-dwell on ch6
        do_reset();
        bus.req = 8'h40;
        wait_cnt(1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_grant", bus.grant, 0);
        chk("t6_sv", bus.sel_valid, 0);
        chk("t6_s", bus.s, 0);
        chk("t6_busy", bus.busy, 0);
        model_reset();
        bus.req = 8'h41;
        @(negedge clk);
        rst = 1'b0;
        cyc();
        chk("t6_first", bus.grant, 8'h01);

        // 7: random traffic against the reference
        do_reset();
        bus.req = 8'($urandom);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) bus.req = 8'($urandom);
            bus.ack = ($urandom_range(0, 3) == 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
